// File: rtl/m_spi_master_if.sv
// ---------------------------------------------------------------------------
// m_spi_master_if
// Register-access bus between the SPI control sequencer and m_spi_master.
//   I_TX_EN / I_WADDR / I_WDATA : one-cycle register write strobe, address, data
//   I_RX_EN / I_RADDR           : one-cycle register read strobe, address
//   O_RDATA                     : registered read data, held until next read
// Modports: master = sequencer side, slave = SPI engine side.
// ---------------------------------------------------------------------------
interface m_spi_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  I_TX_EN;
    logic [2:0]            I_WADDR;
    logic [DATA_WIDTH-1:0] I_WDATA;
    logic                  I_RX_EN;
    logic [2:0]            I_RADDR;
    logic [DATA_WIDTH-1:0] O_RDATA;

    modport master (
        output I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR,
        input  O_RDATA
    );

    modport slave (
        input  I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR,
        output O_RDATA
    );
endinterface

// File: rtl/m_spi_master.sv
// ---------------------------------------------------------------------------
// m_spi_master
// SPI mode-0 master engine with a small register file.
//   I_CLK, I_RST : system clock, asynchronous active-high reset
//   bus          : register write/read bus (m_spi_master_if.slave)
//   O_SCLK       : SPI clock, idle low
//   O_MOSI       : serial data out
//   I_MISO       : serial data in
//   O_SS_N       : active-low slave selects, ~(EN & SSMASK[i]), registered
// Registers: 0 RXDATA (ro), 1 TXDATA (wo), 2 STATUS, 3 CONTROL, 4 SSMASK.
// ---------------------------------------------------------------------------
module m_spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int SS_WIDTH   = 1
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    m_spi_master_if.slave       bus,
    output logic                O_SCLK,
    output logic                O_MOSI,
    input  logic                I_MISO,
    output logic [SS_WIDTH-1:0] O_SS_N
);
    localparam int HCW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state_q, state_nxt;

    logic [DATA_WIDTH-1:0] ctrl_q, ssmask_q, hold_q, rxdata_q;
    logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q, rdata_q, rd_mux, status_w;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic                  hold_full_q, rxrdy_q, roe_q, msbf_q;
    logic                  sclk_q, mosi_q, tx_next_bit;
    logic [1:0]            div_q, div_cnt_q;
    logic [HCW-1:0]        half_cnt_q;
    logic [SS_WIDTH-1:0]   ss_n_q;

    logic en_nxt, half_end, last_half, rd_rxdata;
    logic do_load, do_done, do_abort;

    assign O_SCLK      = sclk_q;
    assign O_MOSI      = mosi_q;
    assign O_SS_N      = ss_n_q;
    assign bus.O_RDATA = rdata_q;

    // EN as it will be after this edge, so a CONTROL write clearing EN
    // aborts the shifter on the very edge it lands.
    assign en_nxt    = (bus.I_TX_EN && (bus.I_WADDR == 3'd3)) ? bus.I_WDATA[7] : ctrl_q[7];
    assign half_end  = (div_cnt_q == div_q);
    assign last_half = half_end && (half_cnt_q == HCW'(2 * DATA_WIDTH - 1));
    assign rd_rxdata = bus.I_RX_EN && (bus.I_RADDR == 3'd0);

    assign tx_shifted  = msbf_q ? {tx_sh_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
    assign tx_next_bit = msbf_q ? tx_sh_q[DATA_WIDTH-2] : tx_sh_q[1];

    always_comb begin
        status_w    = '0;
        status_w[6] = rxrdy_q;
        status_w[5] = (state_q == ST_IDLE);
        status_w[4] = ~hold_full_q;
        status_w[3] = roe_q;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.I_RADDR)
            3'd0:    rd_mux = rxdata_q;
            3'd2:    rd_mux = status_w;
            3'd3:    rd_mux = ctrl_q;
            3'd4:    rd_mux = ssmask_q;
            default: rd_mux = '0;
        endcase
    end

    // Shifter FSM: state register
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Shifter FSM: next state and datapath controls
    always_comb begin
        state_nxt = state_q;
        do_load   = 1'b0;
        do_done   = 1'b0;
        do_abort  = 1'b0;
        if (!en_nxt) begin
            do_abort  = 1'b1;
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        do_load   = 1'b1;
                        state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_half) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    do_done = 1'b1;
                    if (hold_full_q) begin
                        do_load   = 1'b1;
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Register file, shifter datapath and outputs
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            ctrl_q      <= '0;
            ssmask_q    <= '0;
            hold_q      <= '0;
            rxdata_q    <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rdata_q     <= '0;
            hold_full_q <= 1'b0;
            rxrdy_q     <= 1'b0;
            roe_q       <= 1'b0;
            msbf_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            div_q       <= '0;
            div_cnt_q   <= '0;
            half_cnt_q  <= '0;
            ss_n_q      <= '1;
        end else begin
            ss_n_q <= ~({SS_WIDTH{ctrl_q[7]}} & ssmask_q[SS_WIDTH-1:0]);

            if (bus.I_TX_EN) begin
                case (bus.I_WADDR)
                    3'd1: begin
                        if (ctrl_q[7] && !hold_full_q) begin
                            hold_q      <= bus.I_WDATA;
                            hold_full_q <= 1'b1;
                        end
                    end
                    3'd2:    roe_q    <= 1'b0;
                    3'd3:    ctrl_q   <= bus.I_WDATA;
                    3'd4:    ssmask_q <= bus.I_WDATA;
                    default: ;
                endcase
            end

            if (bus.I_RX_EN) begin
                rdata_q <= rd_mux;
                if (rd_rxdata) begin
                    rxrdy_q <= 1'b0;
                end
            end

            if (do_abort) begin
                sclk_q      <= 1'b0;
                mosi_q      <= 1'b0;
                hold_full_q <= 1'b0;
            end else if (state_q == ST_SHIFT) begin
                if (half_end) begin
                    // DIV is re-latched only here so a change applies from the next half-period.
                    div_cnt_q  <= '0;
                    div_q      <= ctrl_q[1:0];
                    half_cnt_q <= half_cnt_q + 1'b1;
                    sclk_q     <= ~sclk_q;
                    if (!sclk_q) begin
                        rx_sh_q <= msbf_q ? {rx_sh_q[DATA_WIDTH-2:0], I_MISO}
                                          : {I_MISO, rx_sh_q[DATA_WIDTH-1:1]};
                    end else begin
                        tx_sh_q <= tx_shifted;
                        mosi_q  <= tx_next_bit;
                    end
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
            end

            if (do_done) begin
                rxdata_q <= rx_sh_q;
                rxrdy_q  <= 1'b1;
                if (rxrdy_q && !rd_rxdata) begin
                    roe_q <= 1'b1;
                end
                mosi_q <= 1'b0;
            end

            if (do_load) begin
                tx_sh_q     <= hold_q;
                msbf_q      <= ctrl_q[3];
                mosi_q      <= ctrl_q[3] ? hold_q[DATA_WIDTH-1] : hold_q[0];
                div_q       <= ctrl_q[1:0];
                div_cnt_q   <= '0;
                half_cnt_q  <= '0;
                sclk_q      <= 1'b0;
                hold_full_q <= 1'b0;
            end
        end
    end
endmodule
